// File: rtl/program_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to
// instruction memory from address 0, and holds the processor until the image is complete.
module program_loader #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_wen,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] FULL_IMAGE = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_BYTES,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t          state, state_nx;
   logic [TW-1:0]   idle_cnt;
   logic [1:0]      idx;
   logic [ADDR_W:0] remaining;
   logic            loading, accept, timed_out, last_byte, last_word;

   // accept is derived from state rather than byte_ready to keep the FSM block loop-free
   assign loading   = (state == S_COUNT) || (state == S_BYTES);
   assign accept    = byte_valid && loading;
   assign timed_out = !accept && (idle_cnt == TW'(TIMEOUT - 1));
   assign last_byte = (idx == 2'd3);
   assign last_word = (remaining == (ADDR_W+1)'(1));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      mem_wen    = 1'b0;
      cpu_hold   = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_IDLE: if (start) state_nx = S_COUNT;
         S_COUNT: begin
            byte_ready = 1'b1;
            if (accept)         state_nx = S_BYTES;
            else if (timed_out) state_nx = S_ERROR;
         end
         S_BYTES: begin
            byte_ready = 1'b1;
            if (accept && last_byte) state_nx = S_WRITE;
            else if (timed_out)      state_nx = S_ERROR;
         end
         S_WRITE: begin
            mem_wen  = 1'b1;
            state_nx = last_word ? S_DONE : S_BYTES;
         end
         S_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start) state_nx = S_COUNT;
         end
         S_ERROR: begin
            error = 1'b1;
            if (start) state_nx = S_COUNT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // A count byte of zero selects the full 2^ADDR_W-word image
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mem_addr  <= '0;
         mem_data  <= '0;
         idx       <= '0;
         idle_cnt  <= '0;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  mem_addr <= '0;
                  idx      <= '0;
                  idle_cnt <= '0;
               end
            end
            S_COUNT, S_BYTES: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (state == S_COUNT) begin
                     remaining <= (byte_in == 8'h00) ? FULL_IMAGE : (ADDR_W+1)'(byte_in);
                  end else begin
                     mem_data <= {mem_data[23:0], byte_in};
                     idx      <= idx + 2'd1;
                  end
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_WRITE: begin
               remaining <= remaining - (ADDR_W+1)'(1);
               if (!last_word) mem_addr <= mem_addr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
